// File: rtl/cordic_vector_iter_pkg.sv
// rtl/cordic_vector_iter_pkg.sv - shared CORDIC constants, arctangent table and FSM state type
package cordic_vector_iter_pkg;

    localparam int MAX_ITER = 16;
    localparam int CNT_W    = 4;

    // Angles scaled so that 2^15 == pi (16-bit angle word); PI_2 is a quarter turn.
    localparam int PI_2 = 16384;

    // Un-compensated vector gain after the micro-rotations, K ~= 1.6468; the downstream
    // gain-compensation stage multiplies by 1/K ~= 0.6073 with shift-adds.
    localparam real CORDIC_GAIN = 1.6468;

    localparam int ATAN_TABLE [MAX_ITER] = '{
        8192, 4836, 2555, 1297, 651, 326, 163, 81,
        41,   20,   10,   5,    3,   1,   1,   0
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    function automatic int atan_lookup(input logic [CNT_W-1:0] idx);
        return ATAN_TABLE[idx];
    endfunction

endpackage

// File: rtl/cordic_vector_iter_if.sv
// rtl/cordic_vector_iter_if.sv - input/output valid-ready bundle for the vectoring CORDIC
interface cordic_vector_iter_if #(
    parameter int DATA_WIDTH  = 15,
    parameter int ANGLE_WIDTH = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_WIDTH-1:0]  X_in;
    logic signed [DATA_WIDTH-1:0]  Y_in;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [DATA_WIDTH+1:0]  X_out;
    logic signed [ANGLE_WIDTH-1:0] Z_out;

    modport master (
        output in_valid, X_in, Y_in, out_ready,
        input  in_ready, out_valid, X_out, Z_out
    );

    modport slave (
        input  in_valid, X_in, Y_in, out_ready,
        output in_ready, out_valid, X_out, Z_out
    );
endinterface

// File: rtl/cordic_vector_iter_stage.sv
// rtl/cordic_vector_iter_stage.sv - one combinational vectoring micro-rotation
module cordic_vector_stage #(
    parameter int W  = 17,
    parameter int AW = 16,
    parameter int IW = 4
) (
    input  logic signed [W-1:0]  x_i,
    input  logic signed [W-1:0]  y_i,
    input  logic signed [AW-1:0] z_i,
    input  logic        [IW-1:0] i_i,
    input  logic signed [AW-1:0] atan_i,
    output logic signed [W-1:0]  x_o,
    output logic signed [W-1:0]  y_o,
    output logic signed [AW-1:0] z_o
);
    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;

    assign x_sh = x_i >>> i_i;
    assign y_sh = y_i >>> i_i;

    // Drive y toward zero: rotate clockwise while y is non-negative.
    always_comb begin
        if (!y_i[W-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end
    end
endmodule

// File: rtl/cordic_vector_iter.sv
// rtl/cordic_vector_iter.sv - iterative vectoring CORDIC: magnitude (gain K) and atan2 of (X,Y)
module cordic_vector_iter
    import cordic_vector_iter_pkg::*;
#(
    parameter int DATA_WIDTH  = 15,
    parameter int ANGLE_WIDTH = 16,
    parameter int ITER        = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_vector_iter_if.slave  bus
);
    localparam int W = DATA_WIDTH + 2;
    localparam logic [CNT_W-1:0]            LAST   = CNT_W'(ITER - 1);
    localparam logic signed [ANGLE_WIDTH-1:0] Z_PI_2 = ANGLE_WIDTH'(PI_2);

    state_e state_q, state_d;

    logic signed [W-1:0]           x_q, x_d, y_q, y_d;
    logic signed [ANGLE_WIDTH-1:0] z_q, z_d;
    logic        [CNT_W-1:0]       count_q, count_d;
    logic                          zero_q, zero_d;
    logic signed [W-1:0]           x_out_q, x_out_d;
    logic signed [ANGLE_WIDTH-1:0] z_out_q, z_out_d;

    logic signed [W-1:0]           x_ext, y_ext, x_nx, y_nx;
    logic signed [ANGLE_WIDTH-1:0] z_nx, atan_cur;

    assign x_ext    = {{2{bus.X_in[DATA_WIDTH-1]}}, bus.X_in};
    assign y_ext    = {{2{bus.Y_in[DATA_WIDTH-1]}}, bus.Y_in};
    assign atan_cur = ANGLE_WIDTH'(atan_lookup(count_q));

    cordic_vector_stage #(
        .W  (W),
        .AW (ANGLE_WIDTH),
        .IW (CNT_W)
    ) u_stage (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .i_i    (count_q),
        .atan_i (atan_cur),
        .x_o    (x_nx),
        .y_o    (y_nx),
        .z_o    (z_nx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.in_valid)    state_d = S_ROTATE;
            S_ROTATE: if (count_q == LAST) state_d = S_DONE;
            S_DONE:   if (bus.out_ready)   state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        count_d = count_q;
        zero_d  = zero_q;
        x_out_d = x_out_q;
        z_out_d = z_out_q;
        if (state_q == S_IDLE && bus.in_valid) begin
            // Pre-rotate left-half-plane vectors by +/-90 degrees so the iterations converge.
            count_d = '0;
            zero_d  = (bus.X_in == '0) && (bus.Y_in == '0);
            if (!x_ext[W-1]) begin
                x_d = x_ext;  y_d = y_ext;  z_d = '0;
            end else if (!y_ext[W-1]) begin
                x_d = y_ext;  y_d = -x_ext; z_d = Z_PI_2;
            end else begin
                x_d = -y_ext; y_d = x_ext;  z_d = -Z_PI_2;
            end
        end else if (state_q == S_ROTATE) begin
            x_d     = x_nx;
            y_d     = y_nx;
            z_d     = z_nx;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST) begin
                // A zero vector has no angle; report 0 instead of the accumulated table sum.
                x_out_d = x_nx;
                z_out_d = zero_q ? '0 : z_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
            x_out_q <= '0;
            z_out_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            x_out_q <= x_out_d;
            z_out_q <= z_out_d;
        end
    end

    assign bus.X_out = x_out_q;
    assign bus.Z_out = z_out_q;
endmodule

// File: tb/tb_cordic_vector_iter.sv
// tb/tb_cordic_vector_iter.sv - self-checking bench for cordic_vector_iter
module tb_cordic_vector_iter;
    localparam int DW   = 15;
    localparam int AW   = 16;
    localparam int ITER = 12;
    localparam real PI  = 3.141592653589793;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    int ATAN [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};

    cordic_vector_iter_if #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) bus ();

    cordic_vector_iter #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit-exact reference: quadrant fold, then ITER truncating micro-rotations on plain ints.
    function automatic void ref_model(input int xi, input int yi, output int xo, output int zo);
        int x, y, z, t;
        logic [15:0] zw;
        if (xi == 0 && yi == 0) begin
            xo = 0; zo = 0;
            return;
        end
        if (xi >= 0)      begin x = xi;  y = yi;  z = 0;      end
        else if (yi >= 0) begin x = yi;  y = -xi; z = 16384;  end
        else              begin x = -yi; y = xi;  z = -16384; end
        for (int i = 0; i < ITER; i++) begin
            if (y >= 0) begin t = x + (y >>> i); y = y - (x >>> i); x = t; z = z + ATAN[i]; end
            else        begin t = x - (y >>> i); y = y + (x >>> i); x = t; z = z - ATAN[i]; end
        end
        zw = z[15:0];
        xo = x;
        zo = int'($signed(zw));
    endfunction

    function automatic bit near_ideal(input int xi, input int yi, input int xo, input int zo);
        real k, ex, ez, dz;
        k = 1.0;
        for (int i = 0; i < ITER; i++) k = k * $sqrt(1.0 + 1.0 / real'(1 << (2 * i)));
        ex = k * $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
        ez = $atan2(real'(yi), real'(xi)) * 32768.0 / PI;
        dz = real'(zo) - ez;
        while (dz > 32768.0)  dz = dz - 65536.0;
        while (dz < -32768.0) dz = dz + 65536.0;
        return ((real'(xo) - ex) <= 16.0) && ((ex - real'(xo)) <= 16.0) && (dz <= 16.0) && (dz >= -16.0);
    endfunction

    task automatic run_vector(input int xi, input int yi, output int xo, output int zo,
                              output int lat, output int acc_cyc, output bit rot_bad);
        int w;
        rot_bad = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        bus.X_in = DW'(xi);
        bus.Y_in = DW'(yi);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rot_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        xo = bus.X_out;
        zo = bus.Z_out;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++;
        if (bus.X_out !== '0) $display("FAIL reset_X_out got %0d want 0", bus.X_out); else pass_cnt++;
        total_cnt++;
        if (bus.Z_out !== '0) $display("FAIL reset_Z_out got %0d want 0", bus.Z_out); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_directed();
        int xs [6] = '{1000, 1000, 0, -1000, -16384, 0};
        int ys [6] = '{0, 1000, -1000, 0, -16384, 0};
        int xo, zo, lat, acc, ex, ez;
        bit rb;
        for (int n = 0; n < 6; n++) begin
            run_vector(xs[n], ys[n], xo, zo, lat, acc, rb);
            ref_model(xs[n], ys[n], ex, ez);
            total_cnt++;
            if (lat !== ITER) $display("FAIL dir%0d_latency got %0d want %0d", n, lat, ITER); else pass_cnt++;
            total_cnt++;
            if (rb) $display("FAIL dir%0d_rotate_in_ready got 1 want 0", n); else pass_cnt++;
            total_cnt++;
            if (xo !== ex || zo !== ez)
                $display("FAIL dir%0d_result got X=%0d Z=%0d want X=%0d Z=%0d", n, xo, zo, ex, ez);
            else pass_cnt++;
            if (xs[n] != 0 || ys[n] != 0) begin
                total_cnt++;
                if (!near_ideal(xs[n], ys[n], xo, zo))
                    $display("FAIL dir%0d_ideal got X=%0d Z=%0d want near K*|v| and atan2", n, xo, zo);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        int xi, yi, xo, zo, lat, acc, ex, ez;
        bit rb;
        for (int n = 0; n < 24; n++) begin
            xi = int'($urandom_range(0, 32767)) - 16384;
            yi = int'($urandom_range(0, 32767)) - 16384;
            run_vector(xi, yi, xo, zo, lat, acc, rb);
            ref_model(xi, yi, ex, ez);
            total_cnt++;
            if (xo !== ex || zo !== ez)
                $display("FAIL rand%0d (%0d,%0d) got X=%0d Z=%0d want X=%0d Z=%0d", n, xi, yi, xo, zo, ex, ez);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int ex, ez, hx, hz, lat, xo, zo;
        bit stable;
        bus.X_in = DW'(1000); bus.Y_in = DW'(500); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.X_in = DW'(-2000); bus.Y_in = DW'(300);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        hx = bus.X_out; hz = bus.Z_out;
        ref_model(1000, 500, ex, ez);
        total_cnt++;
        if (hx !== ex || hz !== ez) $display("FAIL bp_first got X=%0d Z=%0d want X=%0d Z=%0d", hx, hz, ex, ez); else pass_cnt++;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.X_out !== DW'(hx) + 17'sd0 || bus.Z_out !== AW'(hz) || !bus.out_valid || bus.in_ready) stable = 1'b0;
        end
        total_cnt++;
        if (!stable) $display("FAIL bp_hold got unstable/accepting want held outputs, in_ready=0"); else pass_cnt++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL bp_release got in_ready=%0b out_valid=%0b want 1 0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_second_accept got in_ready=%0b want 0", bus.in_ready); else pass_cnt++;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        xo = bus.X_out; zo = bus.Z_out;
        ref_model(-2000, 300, ex, ez);
        total_cnt++;
        if (lat !== ITER || xo !== ex || zo !== ez)
            $display("FAIL bp_second got lat=%0d X=%0d Z=%0d want lat=%0d X=%0d Z=%0d", lat, xo, zo, ITER, ex, ez);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int xo, zo, lat, acc, ex, ez;
        bit rb;
        bus.X_in = DW'(3000); bus.Y_in = DW'(-2000); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.X_out !== '0 || bus.Z_out !== '0)
            $display("FAIL midreset_outputs got v=%0b X=%0d Z=%0d want 0 0 0", bus.out_valid, bus.X_out, bus.Z_out);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL midreset_in_ready got %0b want 1", bus.in_ready); else pass_cnt++;
        run_vector(1000, 0, xo, zo, lat, acc, rb);
        ref_model(1000, 0, ex, ez);
        total_cnt++;
        if (lat !== ITER || xo !== ex || zo !== ez)
            $display("FAIL midreset_next got lat=%0d X=%0d Z=%0d want lat=%0d X=%0d Z=%0d", lat, xo, zo, ITER, ex, ez);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int xo, zo, lat, acc, prev_acc, ex, ez, xi, yi;
        bit rb;
        prev_acc = -1;
        for (int n = 0; n < 4; n++) begin
            xi = int'($urandom_range(0, 32767)) - 16384;
            yi = int'($urandom_range(0, 32767)) - 16384;
            run_vector(xi, yi, xo, zo, lat, acc, rb);
            ref_model(xi, yi, ex, ez);
            total_cnt++;
            if (xo !== ex || zo !== ez)
                $display("FAIL b2b%0d_result got X=%0d Z=%0d want X=%0d Z=%0d", n, xo, zo, ex, ez);
            else pass_cnt++;
            if (prev_acc >= 0) begin
                total_cnt++;
                if (acc - prev_acc !== ITER + 2)
                    $display("FAIL b2b%0d_period got %0d want %0d", n, acc - prev_acc, ITER + 2);
                else pass_cnt++;
            end
            prev_acc = acc;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.X_in      = '0;
        bus.Y_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached, passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
